// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, mode-field layout and the baud divisor table.
// Used by both the transmit and receive engines.
package uart_pkg;

  localparam int DATA_W          = 8;
  localparam int CNT_W           = 16;
  localparam int MODE_W          = 4;
  localparam int MODE_BAUD_LSB   = 0;
  localparam int MODE_BAUD_MSB   = 2;
  localparam int MODE_PARITY_BIT = 3;
  localparam logic [MODE_W-1:0] MODE_RESET = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit for a baud select; unused code 7 falls back to 115200.
  function automatic logic [CNT_W-1:0] baud_divisor(input logic [2:0] sel,
                                                    input int unsigned clk_freq);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 9600;
      3'd1:    baud = 115200;
      3'd2:    baud = 19200;
      3'd3:    baud = 38400;
      3'd4:    baud = 57600;
      3'd5:    baud = 230400;
      3'd6:    baud = 460800;
      default: baud = 115200;
    endcase
    return CNT_W'(clk_freq / baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; o_tc marks the last cycle of the current bit.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter fed from a show-ahead FIFO: 8N1 or 8E1 frames, baud picked per frame.
// tx_line is registered and forced high asynchronously by reset.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [MODE_W-1:0] mode,
  output logic              tx_line,
  output logic              busy
);

  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [MODE_W-1:0] r_frame_mode;
  logic [2:0]        r_bit_cnt;
  logic              r_parity;
  logic              r_tx;

  logic              w_accept;
  logic              w_tc;
  logic              w_load;
  logic              w_cnt_en;
  logic              w_tx_nxt;
  logic [CNT_W-1:0]  w_load_val;

  assign w_accept = data_valid && (r_state == ST_IDLE);

  uart_baud_gen u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (data_valid) w_state_nxt = ST_START;
      ST_START:  if (w_tc) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_tc && (r_bit_cnt == 3'd7)) begin
          w_state_nxt = r_frame_mode[MODE_PARITY_BIT] ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_tc) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tc) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Line level is chosen for the state being entered so the registered output lines up with it.
  always_comb begin
    data_ready = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    w_cnt_en   = (r_state != ST_IDLE);
    w_load     = w_accept ||
                 (w_tc && ((r_state == ST_START) || (r_state == ST_DATA) ||
                           (r_state == ST_PARITY)));
    if (w_accept) begin
      w_load_val = baud_divisor(mode[MODE_BAUD_MSB:MODE_BAUD_LSB], CLK_FREQ) - 1'b1;
    end else begin
      w_load_val = baud_divisor(r_frame_mode[MODE_BAUD_MSB:MODE_BAUD_LSB], CLK_FREQ) - 1'b1;
    end
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_IDLE:   w_tx_nxt = 1'b1;
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = ((r_state == ST_DATA) && w_tc) ? r_shift[1] : r_shift[0];
      ST_PARITY: w_tx_nxt = r_parity;
      ST_STOP:   w_tx_nxt = 1'b1;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx         <= 1'b1;
      r_shift      <= '0;
      r_frame_mode <= MODE_RESET;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_accept) begin
        r_shift      <= data_in;
        r_frame_mode <= mode;
        r_bit_cnt    <= '0;
        r_parity     <= ^data_in;
      end else if ((r_state == ST_DATA) && w_tc) begin
        r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign tx_line = r_tx;

endmodule
